// File: rtl/hub75_pkg.sv
// Shared types and helpers for the HUB75 binary-coded-modulation scanner.
package hub75_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_BLANK,
    ST_LATCH,
    ST_DISPLAY
  } state_e;

  // Column period phases: framebuffer read issued, then read data captured.
  localparam int PH_READ    = 0;
  localparam int PH_CAPTURE = 1;

  // Pixels are packed {R,G,B}, each channel 'bits' wide, zero-padded to 24 bits.
  function automatic int field_off(input int bits, input int chan);
    return (2 - chan) * bits;
  endfunction

  function automatic logic [2:0] rgb_bits(input logic [23:0] px, input int bits,
                                          input int plane);
    return {px[field_off(bits, 0) + plane],
            px[field_off(bits, 1) + plane],
            px[field_off(bits, 2) + plane]};
  endfunction

endpackage

// File: rtl/hub75_bcm_timer.sv
// Display-period timer: loads plane length and on-time at DISPLAY entry,
// then counts both down, driving the panel nOE directly from a flop.
module hub75_bcm_timer #(
  parameter int BITS      = 8,
  parameter int BASE_TIME = 32,
  parameter int PL_W      = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic [PL_W-1:0] plane_i,
  input  logic [7:0]      brightness_i,
  output logic            noe_o,
  output logic            done_o
);
  import hub75_pkg::*;

  localparam int CNT_W  = $clog2(BASE_TIME) + BITS;
  localparam int PROD_W = CNT_W + 9;

  logic [CNT_W-1:0]  period;
  logic [8:0]        bri_p1;
  logic [PROD_W-1:0] prod;
  logic [CNT_W-1:0]  on_val;
  logic [CNT_W-1:0]  cnt_q, on_q;
  logic              noe_q;

  assign period = CNT_W'(BASE_TIME) << plane_i;
  assign bri_p1 = {1'b0, brightness_i} + 9'd1;
  assign prod   = PROD_W'(period) * PROD_W'(bri_p1);
  assign on_val = CNT_W'(prod >> 8);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      on_q  <= '0;
      noe_q <= 1'b1;
    end else if (load_i) begin
      cnt_q <= period;
      on_q  <= on_val;
      noe_q <= (on_val == '0);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
      on_q  <= (on_q != '0) ? on_q - CNT_W'(1) : '0;
      // Blank after the on-time runs out, and always once the period ends.
      noe_q <= (cnt_q == CNT_W'(1)) || (on_q <= CNT_W'(1));
    end
  end

  assign noe_o  = noe_q;
  assign done_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/hub75_bcm_driver.sv
// HUB75 panel scanner: shifts one bit-plane per row, latches it, then shows it
// for BASE_TIME<<plane cycles scaled by brightness. All pin outputs are flops.
module hub75_bcm_driver #(
  parameter int COLS      = 64,
  parameter int ROWS      = 64,
  parameter int BITS      = 8,
  parameter int CLK_DIV   = 2,
  parameter int BASE_TIME = 32,
  parameter int COL_W     = $clog2(COLS),
  parameter int ROW_W     = $clog2(ROWS/2)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [7:0]             brightness,
  output logic                   rd_en,
  output logic [ROW_W+COL_W-1:0] rd_addr,
  input  logic [3*BITS-1:0]      rd_data_top,
  input  logic [3*BITS-1:0]      rd_data_bot,
  output logic [2:0]             to_screen_RGB0,
  output logic [2:0]             to_screen_RGB1,
  output logic                   to_screen_CLK,
  output logic [ROW_W-1:0]       to_screen_ABCDE,
  output logic                   to_screen_LATCH,
  output logic                   to_screen_nOE,
  output logic                   frame_start
);
  import hub75_pkg::*;

  localparam int PH_W = $clog2(2*CLK_DIV);
  localparam int PL_W = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2*CLK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_HI    = PH_W'(CLK_DIV);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS/2 - 1);
  localparam logic [PL_W-1:0]  PL_LAST  = PL_W'(BITS - 1);

  state_e                   state_q, state_d;
  logic [PH_W-1:0]          ph_q, ph_d;
  logic [COL_W-1:0]         col_q, col_d;
  logic [ROW_W-1:0]         row_q, row_d;
  logic [PL_W-1:0]          plane_q, plane_d;
  logic                     fs_q, fs_d;
  logic                     rd_en_q, rd_en_d;
  logic [ROW_W+COL_W-1:0]   rd_addr_q, rd_addr_d;
  logic                     sclk_q, sclk_d;
  logic                     latch_q, latch_d;
  logic [ROW_W-1:0]         abcde_q, abcde_d;
  logic [2:0]               rgb0_q, rgb0_d, rgb1_q, rgb1_d;
  logic                     tmr_noe, tmr_done;

  hub75_bcm_timer #(
    .BITS      (BITS),
    .BASE_TIME (BASE_TIME),
    .PL_W      (PL_W)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .load_i       (state_q == ST_LATCH),
    .plane_i      (plane_q),
    .brightness_i (brightness),
    .noe_o        (tmr_noe),
    .done_o       (tmr_done)
  );

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    col_d   = col_q;
    row_d   = row_q;
    plane_d = plane_q;
    fs_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_SHIFT;
          ph_d    = '0;
          col_d   = '0;
          row_d   = '0;
          plane_d = '0;
          fs_d    = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (ph_q == PH_LAST) begin
          ph_d = '0;
          if (col_q == COL_LAST) begin
            col_d   = '0;
            state_d = ST_BLANK;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      ST_BLANK: state_d = ST_LATCH;
      ST_LATCH: state_d = ST_DISPLAY;
      ST_DISPLAY: begin
        // en is only honoured here so a plane is never cut short.
        if (tmr_done) begin
          if (!en) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_SHIFT;
            ph_d    = '0;
            col_d   = '0;
            if (plane_q == PL_LAST) begin
              plane_d = '0;
              row_d   = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
              fs_d    = (row_q == ROW_LAST);
            end else begin
              plane_d = plane_q + PL_W'(1);
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pin values are derived from the next state so they line up with state_q.
  always_comb begin
    rd_en_d   = (state_d == ST_SHIFT) && (ph_d == PH_W'(PH_READ));
    rd_addr_d = rd_en_d ? {row_d, col_d} : rd_addr_q;
    sclk_d    = (state_d == ST_SHIFT) && (ph_d >= PH_HI);
    latch_d   = (state_d == ST_LATCH);
    abcde_d   = latch_d ? row_q : abcde_q;
    rgb0_d    = rgb0_q;
    rgb1_d    = rgb1_q;
    if (state_q == ST_SHIFT && ph_q == PH_W'(PH_CAPTURE)) begin
      rgb0_d = rgb_bits(24'(rd_data_top), BITS, int'(plane_q));
      rgb1_d = rgb_bits(24'(rd_data_bot), BITS, int'(plane_q));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ph_q      <= '0;
      col_q     <= '0;
      row_q     <= '0;
      plane_q   <= '0;
      fs_q      <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      sclk_q    <= 1'b0;
      latch_q   <= 1'b0;
      abcde_q   <= '0;
      rgb0_q    <= '0;
      rgb1_q    <= '0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      col_q     <= col_d;
      row_q     <= row_d;
      plane_q   <= plane_d;
      fs_q      <= fs_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      sclk_q    <= sclk_d;
      latch_q   <= latch_d;
      abcde_q   <= abcde_d;
      rgb0_q    <= rgb0_d;
      rgb1_q    <= rgb1_d;
    end
  end

  assign rd_en           = rd_en_q;
  assign rd_addr         = rd_addr_q;
  assign to_screen_RGB0  = rgb0_q;
  assign to_screen_RGB1  = rgb1_q;
  assign to_screen_CLK   = sclk_q;
  assign to_screen_ABCDE = abcde_q;
  assign to_screen_LATCH = latch_q;
  assign to_screen_nOE   = tmr_noe;
  assign frame_start     = fs_q;

endmodule

// File: tb/tb_hub75_bcm_driver.sv
// Directed bench: 4x4 panel, 2 bit-planes, CLK_DIV=2, BASE_TIME=4.
module tb_hub75_bcm_driver;
  localparam int COLS = 4, ROWS = 4, BITS = 2, CLK_DIV = 2, BASE_TIME = 4;
  localparam int COL_W = 2, ROW_W = 1;
  // R=2'b10, G=2'b01, B=2'b11
  localparam logic [5:0] PX_TOP = 6'b10_01_11;

  typedef struct {
    int len, rd, addr_bad, clkp, clkh, lat, lat_row, noe_low, fs;
    logic [2:0] rgb0_and, rgb0_or, rgb1_or;
  } meas_t;

  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [7:0] brightness = 8'd255;
  logic rd_en;
  logic [ROW_W+COL_W-1:0] rd_addr;
  logic [3*BITS-1:0] rd_data_top, rd_data_bot;
  logic [2:0] rgb0, rgb1;
  logic scr_clk, latch, noe, frame_start;
  logic [ROW_W-1:0] abcde;
  int errors = 0, checks = 0;

  hub75_bcm_driver #(
    .COLS(COLS), .ROWS(ROWS), .BITS(BITS), .CLK_DIV(CLK_DIV), .BASE_TIME(BASE_TIME),
    .COL_W(COL_W), .ROW_W(ROW_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .brightness(brightness),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data_top(rd_data_top), .rd_data_bot(rd_data_bot),
    .to_screen_RGB0(rgb0), .to_screen_RGB1(rgb1), .to_screen_CLK(scr_clk),
    .to_screen_ABCDE(abcde), .to_screen_LATCH(latch), .to_screen_nOE(noe),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Framebuffer: data is valid only in the cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data_top <= PX_TOP;
      rd_data_bot <= '0;
    end else begin
      rd_data_top <= '0;
      rd_data_bot <= '0;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  // Measures from the current cycle; window=0 stops at the next plane start.
  task automatic run_plane(input int exp_row, input int first_col, input int window,
                           output meas_t m);
    int c, col;
    logic prev_clk;
    m = '{len: 0, rd: 0, addr_bad: 0, clkp: 0, clkh: 0, lat: 0, lat_row: -1,
          noe_low: 0, fs: 0, rgb0_and: 3'b111, rgb0_or: 3'b000, rgb1_or: 3'b000};
    c = 0;
    col = first_col;
    prev_clk = 1'b0;
    while (c < 400) begin
      if (rd_en) begin
        m.rd++;
        if (int'(rd_addr) != exp_row * COLS + col) m.addr_bad++;
        col++;
      end
      if (scr_clk) m.clkh++;
      if (scr_clk && !prev_clk) begin
        m.clkp++;
        m.rgb0_and &= rgb0;
        m.rgb0_or  |= rgb0;
        m.rgb1_or  |= rgb1;
      end
      prev_clk = scr_clk;
      if (latch) begin
        m.lat++;
        m.lat_row = int'(abcde);
      end
      if (!noe) m.noe_low++;
      if (frame_start) m.fs++;
      step();
      c++;
      if (window > 0 && c >= window) break;
      if (window == 0 && rd_en && rd_addr[COL_W-1:0] == '0) break;
    end
    m.len = c;
  endtask

  task automatic test_reset();
    step(); step(); step();
    checks++; if (noe !== 1'b1) begin errors++; $display("FAIL rst_noe got=%b exp=1", noe); end
    checks++; if (scr_clk !== 1'b0) begin errors++; $display("FAIL rst_clk got=%b exp=0", scr_clk); end
    checks++; if (latch !== 1'b0) begin errors++; $display("FAIL rst_latch got=%b exp=0", latch); end
    checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en got=%b exp=0", rd_en); end
    checks++; if (abcde !== '0) begin errors++; $display("FAIL rst_abcde got=%0d exp=0", abcde); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL rst_fs got=%b exp=0", frame_start); end
    checks++; if (rgb0 !== 3'b000) begin errors++; $display("FAIL rst_rgb0 got=%b exp=000", rgb0); end
    rst = 1'b0;
    en = 1'b1;
    step();
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL start_fs got=%b exp=1", frame_start); end
    checks++; if (rd_en !== 1'b1 || rd_addr !== '0) begin errors++; $display("FAIL start_read got=%b/%0d exp=1/0", rd_en, rd_addr); end
  endtask

  task automatic test_timing_bits();
    meas_t m;
    run_plane(0, 0, 0, m);
    checks++; if (m.len !== 22) begin errors++; $display("FAIL p0_len got=%0d exp=22", m.len); end
    checks++; if (m.clkp !== 4) begin errors++; $display("FAIL p0_clk_pulses got=%0d exp=4", m.clkp); end
    checks++; if (m.clkh !== 8) begin errors++; $display("FAIL p0_clk_high got=%0d exp=8", m.clkh); end
    checks++; if (m.lat !== 1) begin errors++; $display("FAIL p0_latch got=%0d exp=1", m.lat); end
    checks++; if (m.lat_row !== 0) begin errors++; $display("FAIL p0_latch_row got=%0d exp=0", m.lat_row); end
    checks++; if (m.rd !== 4 || m.addr_bad !== 0) begin errors++; $display("FAIL p0_reads got=%0d bad=%0d exp=4 bad=0", m.rd, m.addr_bad); end
    checks++; if (m.rgb0_and !== 3'b011 || m.rgb0_or !== 3'b011) begin errors++; $display("FAIL p0_rgb0 got=%b/%b exp=011", m.rgb0_and, m.rgb0_or); end
    checks++; if (m.rgb1_or !== 3'b000) begin errors++; $display("FAIL p0_rgb1 got=%b exp=000", m.rgb1_or); end
    checks++; if (m.noe_low !== 4) begin errors++; $display("FAIL p0_noe_b255 got=%0d exp=4", m.noe_low); end
    checks++; if (m.fs !== 1) begin errors++; $display("FAIL p0_fs got=%0d exp=1", m.fs); end
    run_plane(0, 0, 0, m);
    checks++; if (m.len !== 26) begin errors++; $display("FAIL p1_len got=%0d exp=26", m.len); end
    checks++; if (m.clkp !== 4) begin errors++; $display("FAIL p1_clk_pulses got=%0d exp=4", m.clkp); end
    checks++; if (m.rgb0_and !== 3'b101 || m.rgb0_or !== 3'b101) begin errors++; $display("FAIL p1_rgb0 got=%b/%b exp=101", m.rgb0_and, m.rgb0_or); end
    checks++; if (m.rgb1_or !== 3'b000) begin errors++; $display("FAIL p1_rgb1 got=%b exp=000", m.rgb1_or); end
    checks++; if (m.noe_low !== 8) begin errors++; $display("FAIL p1_noe_b255 got=%0d exp=8", m.noe_low); end
    checks++; if (m.fs !== 0) begin errors++; $display("FAIL p1_fs got=%0d exp=0", m.fs); end
  endtask

  task automatic test_wrap();
    meas_t m;
    run_plane(1, 0, 0, m);
    checks++; if (m.lat_row !== 1 || m.len !== 22) begin errors++; $display("FAIL r1p0 got row=%0d len=%0d exp row=1 len=22", m.lat_row, m.len); end
    checks++; if (m.addr_bad !== 0 || m.fs !== 0) begin errors++; $display("FAIL r1p0_addr_fs got bad=%0d fs=%0d exp 0/0", m.addr_bad, m.fs); end
    run_plane(1, 0, 0, m);
    checks++; if (m.lat_row !== 1 || m.len !== 26) begin errors++; $display("FAIL r1p1 got row=%0d len=%0d exp row=1 len=26", m.lat_row, m.len); end
    checks++; if (m.fs !== 0) begin errors++; $display("FAIL r1p1_fs got=%0d exp=0", m.fs); end
    run_plane(0, 0, 0, m);
    checks++; if (m.lat_row !== 0 || m.fs !== 1) begin errors++; $display("FAIL wrap got row=%0d fs=%0d exp row=0 fs=1", m.lat_row, m.fs); end
  endtask

  task automatic test_brightness();
    meas_t m;
    brightness = 8'd0;
    run_plane(0, 0, 0, m);
    checks++; if (m.noe_low !== 0 || m.len !== 26) begin errors++; $display("FAIL bri0_p1 got low=%0d len=%0d exp 0/26", m.noe_low, m.len); end
    brightness = 8'd127;
    run_plane(1, 0, 0, m);
    checks++; if (m.noe_low !== 2) begin errors++; $display("FAIL bri127_p0 got=%0d exp=2", m.noe_low); end
  endtask

  task automatic test_enable_drop();
    meas_t m;
    for (int i = 0; i < 5; i++) step();
    en = 1'b0;
    run_plane(1, 2, 115, m);
    checks++; if (m.rd !== 2 || m.addr_bad !== 0) begin errors++; $display("FAIL drop_reads got=%0d bad=%0d exp=2 bad=0", m.rd, m.addr_bad); end
    checks++; if (m.lat !== 1 || m.lat_row !== 1) begin errors++; $display("FAIL drop_latch got=%0d row=%0d exp=1 row=1", m.lat, m.lat_row); end
    checks++; if (m.noe_low !== 4) begin errors++; $display("FAIL drop_bri127_p1 got=%0d exp=4", m.noe_low); end
    checks++; if (m.fs !== 0) begin errors++; $display("FAIL drop_fs got=%0d exp=0", m.fs); end
    checks++; if (noe !== 1'b1 || abcde !== 1'b1) begin errors++; $display("FAIL idle_hold got noe=%b abcde=%0d exp 1/1", noe, abcde); end
  endtask

  task automatic test_restart();
    meas_t m;
    en = 1'b1;
    step();
    checks++; if (frame_start !== 1'b1 || rd_addr !== '0) begin errors++; $display("FAIL restart got fs=%b addr=%0d exp 1/0", frame_start, rd_addr); end
    run_plane(0, 0, 0, m);
    checks++; if (m.len !== 22 || m.lat_row !== 0 || m.addr_bad !== 0) begin errors++; $display("FAIL restart_plane got len=%0d row=%0d bad=%0d exp 22/0/0", m.len, m.lat_row, m.addr_bad); end
  endtask

  task automatic test_reset_mid();
    meas_t m;
    run_plane(0, 0, 0, m);
    for (int i = 0; i < 19; i++) step();
    checks++; if (noe !== 1'b0 || abcde !== 1'b1) begin errors++; $display("FAIL mid_display got noe=%b abcde=%0d exp 0/1", noe, abcde); end
    rst = 1'b1;
    step();
    checks++; if (noe !== 1'b1 || abcde !== '0) begin errors++; $display("FAIL rstdisp got noe=%b abcde=%0d exp 1/0", noe, abcde); end
    rst = 1'b0;
    step();
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL rst_restart_fs got=%b exp=1", frame_start); end
    step(); step();
    checks++; if (scr_clk !== 1'b1) begin errors++; $display("FAIL shift_clk got=%b exp=1", scr_clk); end
    rst = 1'b1;
    step();
    checks++; if (scr_clk !== 1'b0 || rd_en !== 1'b0 || latch !== 1'b0 || noe !== 1'b1) begin errors++; $display("FAIL rstshift got clk=%b rd=%b lat=%b noe=%b exp 0/0/0/1", scr_clk, rd_en, latch, noe); end
    rst = 1'b0;
    run_plane(0, 0, 30, m);
    checks++; if (m.fs !== 1) begin errors++; $display("FAIL rst_fs_once got=%0d exp=1", m.fs); end
  endtask

  initial begin
    test_reset();
    test_timing_bits();
    test_wrap();
    test_brightness();
    test_enable_drop();
    test_restart();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
